// File: rtl/data_mem_responder_if.sv
// Data-memory port bundle between the MEM stage (master) and the memory responder (slave).
// Carries the Req/Ready/Ack handshake plus address, store data, size codes and load result.
interface data_mem_responder_if;
    logic        Req;
    logic        Ready;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [1:0]  MemWrite;
    logic [1:0]  MemRead;
    logic        Ack;
    logic [31:0] ReadData;
    logic        Err;

    modport master (
        output Req, Address, WriteData, MemWrite, MemRead,
        input  Ready, Ack, ReadData, Err
    );

    modport slave (
        input  Req, Address, WriteData, MemWrite, MemRead,
        output Ready, Ack, ReadData, Err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder: Req/Ready/Ack handshake, LATENCY wait cycles, byte/half/word access.
// Optional MISALIGN_TRAP_EN: misaligned word/half accesses are blocked and flagged on Err.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input logic                 Clk,
    input logic                 Reset,
    data_mem_responder_if.slave memBus
);
    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } stateT;

    stateT       state, stateNext;
    logic [3:0]  waitCnt, waitCntNext;
    logic [31:0] addrQ, wdataQ;
    logic [1:0]  memWriteQ, memReadQ;
    logic [31:0] readDataQ;
    logic        errQ;
    logic [31:0] memArray [DEPTH_WORDS];

    logic [31:0]      curAddr, curWdata;
    logic [1:0]       curWrite, curRead;
    logic [1:0]       accessSize;
    logic [IDX_W-1:0] wordIdx;
    logic [31:0]      oldWord, mergedWord, loadValue;
    logic [15:0]      halfSel;
    logic [7:0]       byteSel;
    logic             misaligned;
    logic             enterAck;
    logic             memWe;
    logic             unusedAddrHigh;

    // With LATENCY=0 the commit happens on the accept edge, so IDLE uses the live bus fields.
    always_comb begin
        curAddr  = addrQ;
        curWdata = wdataQ;
        curWrite = memWriteQ;
        curRead  = memReadQ;
        if (state == IDLE) begin
            curAddr  = memBus.Address;
            curWdata = memBus.WriteData;
            curWrite = memBus.MemWrite;
            curRead  = memBus.MemRead;
        end
    end

    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        case (state)
            IDLE: begin
                if (memBus.Req) begin
                    if (LATENCY == 0) begin
                        stateNext = ACK;
                    end else begin
                        stateNext   = BUSY;
                        waitCntNext = WAIT_INIT;
                    end
                end
            end
            BUSY: begin
                if (waitCnt == '0) begin
                    stateNext = ACK;
                end else begin
                    waitCntNext = waitCnt - 4'd1;
                end
            end
            ACK:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign enterAck       = (stateNext == ACK);
    assign wordIdx        = curAddr[IDX_W+1:2];
    assign oldWord        = memArray[wordIdx];
    assign accessSize     = (curWrite != 2'b00) ? curWrite : curRead;
    assign unusedAddrHigh = ^curAddr[31:IDX_W+2];

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((accessSize == 2'b01) && (curAddr[1:0] != 2'b00)) ||
                        ((accessSize == 2'b10) && curAddr[0]);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        halfSel = curAddr[1] ? oldWord[31:16] : oldWord[15:0];
        case (curAddr[1:0])
            2'b00:   byteSel = oldWord[7:0];
            2'b01:   byteSel = oldWord[15:8];
            2'b10:   byteSel = oldWord[23:16];
            default: byteSel = oldWord[31:24];
        endcase
    end

    // Store merge: untouched lanes keep the old word so partial stores are a single-edge RMW.
    always_comb begin
        mergedWord = oldWord;
        case (curWrite)
            2'b01: mergedWord = curWdata;
            2'b10: begin
                if (curAddr[1]) mergedWord[31:16] = curWdata[15:0];
                else            mergedWord[15:0]  = curWdata[15:0];
            end
            2'b11:   mergedWord[{curAddr[1:0], 3'b000} +: 8] = curWdata[7:0];
            default: mergedWord = oldWord;
        endcase
    end

    always_comb begin
        loadValue = '0;
        if (curWrite == 2'b00 && !misaligned) begin
            case (curRead)
                2'b01:   loadValue = oldWord;
                2'b10:   loadValue = {{16{halfSel[15]}}, halfSel};
                2'b11:   loadValue = {{24{byteSel[7]}}, byteSel};
                default: loadValue = '0;
            endcase
        end
    end

    assign memWe = enterAck && (curWrite != 2'b00) && !misaligned && !Reset;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            waitCnt   <= '0;
            addrQ     <= '0;
            wdataQ    <= '0;
            memWriteQ <= '0;
            memReadQ  <= '0;
            readDataQ <= '0;
            errQ      <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (state == IDLE && memBus.Req) begin
                addrQ     <= memBus.Address;
                wdataQ    <= memBus.WriteData;
                memWriteQ <= memBus.MemWrite;
                memReadQ  <= memBus.MemRead;
            end
            if (enterAck) begin
                readDataQ <= loadValue;
                errQ      <= misaligned;
            end
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge Clk) begin
        if (memWe) begin
            memArray[wordIdx] <= mergedWord;
        end
    end

    assign memBus.Ready    = (state == IDLE);
    assign memBus.Ack      = (state == ACK);
    assign memBus.ReadData = readDataQ;
    assign memBus.Err      = errQ;
endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: driver pushes model results, negedge monitor checks each Ack.
// Reference model is a little-endian byte array; honours MISALIGN_TRAP_EN when defined.
`timescale 1ns/1ps
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;
`ifdef MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    data_mem_responder_if memBus();

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .memBus(memBus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int unsigned cyc;
    } expT;

    expT         expQ[$];
    logic [7:0]  modelMem [4*DEPTH];
    int unsigned compared   = 0;
    int unsigned mismatched = 0;
    int unsigned cyc        = 0;
    logic        prevAck    = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Access = size in bytes from the code; write size wins when both are nonzero.
    function automatic void modelAccess(input logic [1:0] wr, input logic [1:0] rd,
                                        input logic [31:0] addr, input logic [31:0] wd,
                                        output logic [31:0] result, output logic err);
        logic [1:0]  size;
        int unsigned nBytes, base, a;
        logic [31:0] v;
        size   = (wr != 2'b00) ? wr : rd;
        nBytes = (size == 2'd1) ? 4 : (size == 2'd2) ? 2 : (size == 2'd3) ? 1 : 0;
        result = '0;
        err    = 1'b0;
        a      = int'(addr);
        if (nBytes == 0) return;
        if (TRAP && (a % nBytes != 0)) begin
            err = 1'b1;
            return;
        end
        base = ((a / 4) % DEPTH) * 4 + ((a % 4) / nBytes) * nBytes;
        if (wr != 2'b00) begin
            for (int unsigned k = 0; k < nBytes; k++) modelMem[base + k] = 8'(wd >> (8 * k));
        end else begin
            v = '0;
            for (int unsigned k = 0; k < nBytes; k++) v = v | (32'(modelMem[base + k]) << (8 * k));
            if (nBytes < 4 && v[8 * nBytes - 1]) v = v | (32'hFFFF_FFFF << (8 * nBytes));
            result = v;
        end
    endfunction

    always @(negedge Clk) begin : monitor
        expT e;
        if (memBus.Ack) begin
            checkEq("ackPulseWidth", 32'(prevAck), 32'd0);
            if (expQ.size() == 0) begin
                checkEq("spuriousAck", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkEq("ackReadData", memBus.ReadData, e.data);
                checkEq("ackErr", 32'(memBus.Err), 32'(e.err));
                checkEq("ackCycle", cyc, e.cyc);
            end
        end
        prevAck = memBus.Ack;
    end

    // Called at a negedge with the responder idle; returns at a negedge with it idle again.
    task automatic doReq(input logic [1:0] wr, input logic [1:0] rd, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] rdSeen, output logic errSeen);
        expT e;
        bit  got;
        got     = 1'b0;
        rdSeen  = '0;
        errSeen = 1'b0;
        checkEq("readyBeforeReq", 32'(memBus.Ready), 32'd1);
        memBus.Req       = 1'b1;
        memBus.Address   = addr;
        memBus.WriteData = wd;
        memBus.MemWrite  = wr;
        memBus.MemRead   = rd;
        modelAccess(wr, rd, addr, wd, e.data, e.err);
        e.cyc = cyc + 1 + LAT;
        expQ.push_back(e);
        for (int i = 0; i < int'(LAT) + 4 && !got; i++) begin
            @(negedge Clk);
            if (memBus.Ack) begin
                got        = 1'b1;
                rdSeen     = memBus.ReadData;
                errSeen    = memBus.Err;
                memBus.Req = 1'b0;
            end else begin
                checkEq("readyWhileBusy", 32'(memBus.Ready), 32'd0);
                memBus.Req       = 1'($urandom_range(0, 1));
                memBus.Address   = $urandom;
                memBus.WriteData = $urandom;
                memBus.MemWrite  = 2'($urandom_range(0, 3));
                memBus.MemRead   = 2'($urandom_range(0, 3));
            end
        end
        if (!got) begin
            checkEq("ackTimeout", 32'd0, 32'd1);
            memBus.Req = 1'b0;
            if (expQ.size() > 0) void'(expQ.pop_back());
        end
        @(negedge Clk);
        checkEq("readyAfterAck", 32'(memBus.Ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rdv, a;
        logic        ev;
        memBus.Req       = 1'b0;
        memBus.Address   = '0;
        memBus.WriteData = '0;
        memBus.MemWrite  = '0;
        memBus.MemRead   = '0;

        #7;
        checkEq("resetReady", 32'(memBus.Ready), 32'd1);
        checkEq("resetAck", 32'(memBus.Ack), 32'd0);
        checkEq("resetReadData", memBus.ReadData, 32'd0);
        checkEq("resetErr", 32'(memBus.Err), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        for (int unsigned i = 0; i < 16; i++) doReq(2'b01, 2'b00, 32'(i * 4), $urandom, rdv, ev);

        doReq(2'b01, 2'b00, 32'h10, 32'hDEAD_BEEF, rdv, ev);
        doReq(2'b00, 2'b01, 32'h10, '0, rdv, ev);
        checkEq("wordLoad", rdv, 32'hDEAD_BEEF);
        doReq(2'b00, 2'b01, 32'h10 + 4 * DEPTH, '0, rdv, ev);
        checkEq("wordLoadWrap", rdv, 32'hDEAD_BEEF);

        doReq(2'b01, 2'b00, 32'h10, 32'h0, rdv, ev);
        doReq(2'b11, 2'b00, 32'h11, 32'h80, rdv, ev);
        doReq(2'b00, 2'b01, 32'h10, '0, rdv, ev);
        checkEq("byteMergeWord", rdv, 32'h0000_8000);
        doReq(2'b00, 2'b11, 32'h11, '0, rdv, ev);
        checkEq("byteLoadSext", rdv, 32'hFFFF_FF80);
        doReq(2'b00, 2'b10, 32'h10, '0, rdv, ev);
        checkEq("halfLoadSext", rdv, 32'hFFFF_8000);
        doReq(2'b00, 2'b00, 32'h10, '0, rdv, ev);
        checkEq("noOpReadData", rdv, 32'h0);

        doReq(2'b01, 2'b00, 32'h20, 32'h1111_1111, rdv, ev);
        doReq(2'b00, 2'b01, 32'h10, '0, rdv, ev);

        // Abandoned store: reset pulsed while BUSY; no Ack expected, array unchanged.
        memBus.Req       = 1'b1;
        memBus.Address   = 32'h20;
        memBus.WriteData = 32'h1234_5678;
        memBus.MemWrite  = 2'b01;
        memBus.MemRead   = 2'b00;
        @(negedge Clk);
        memBus.Req = 1'b0;
        checkEq("busyBeforeAbort", 32'(memBus.Ready), 32'd0);
        #2 Reset = 1'b1;
        #1;
        checkEq("abortReady", 32'(memBus.Ready), 32'd1);
        checkEq("abortAck", 32'(memBus.Ack), 32'd0);
        checkEq("abortReadData", memBus.ReadData, 32'd0);
        checkEq("abortErr", 32'(memBus.Err), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (LAT + 3) @(negedge Clk);
        doReq(2'b00, 2'b01, 32'h20, '0, rdv, ev);
        checkEq("abortedStoreDropped", rdv, 32'h1111_1111);

        doReq(2'b01, 2'b00, 32'h22, 32'hCAFE_F00D, rdv, ev);
        checkEq("misalignStoreErr", 32'(ev), 32'(TRAP));
        doReq(2'b00, 2'b01, 32'h20, '0, rdv, ev);
        checkEq("misalignStoreEffect", rdv, TRAP ? 32'h1111_1111 : 32'hCAFE_F00D);

        for (int i = 0; i < 250; i++) begin
            a        = $urandom;
            a[11:6]  = '0;
            doReq(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), a, $urandom, rdv, ev);
        end

        repeat (3) @(negedge Clk);
        checkEq("queueDrained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
